// File: rtl/uart_rx_frontend.sv
// Oversampled 8N1 UART receiver with a 1-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_err output.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [15:0]            cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   commit, ferr;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
`endif

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign busy = (state_q != IDLE);

  // Synchroniser resets to the idle line level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    commit  = 1'b0;
    ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (cnt_q == LAST) begin
        cnt_d   = '0;
        shift_d = {rxs, shift_q[7:1]};
        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == LAST) begin
        cnt_d   = '0;
        par_d   = rxs;
        state_d = STOP;
      end
`endif
      STOP: if (cnt_q == LAST) begin
        cnt_d = '0;
        if (rxs) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          ferr    = 1'b1;
          state_d = BRK;
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Shift/parity capture is pure datapath; control decides when it is consumed.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  // Holding register: a commit may land in the same cycle the old byte is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= ferr;
      overrun   <= commit && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
      parity_err <= commit && ((^shift_q) ^ par_q);
`endif
      if (commit && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at CLKS_PER_BIT=16, SYNC_STAGES=2.
// Build with UART_RX_PARITY_EN defined to also cover 8E1 frames.
module tb_uart_rx_frontend;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  int vcyc, acc, ferr_cnt, ovr_cnt, perr_cnt, busy_run, busy_max;
  logic [7:0] acc_data;

  uart_rx_frontend #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) vcyc++;
    if (rx_valid && rx_ready) begin
      acc++;
      acc_data = rx_data;
    end
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
    if (busy) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
  end

  task automatic clear_counts();
    vcyc = 0; acc = 0; ferr_cnt = 0; ovr_cnt = 0; perr_cnt = 0;
    busy_run = 0; busy_max = 0; acc_data = 8'h00;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    RX = b;
    cycles(CPB);
  endtask

  // par_bad flips the even-parity bit when the parity build is active.
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input logic par_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_bad);
`endif
    send_bit(stop_lvl);
    RX = 1'b1;
  endtask

  initial begin
    rst = 1'b1; RX = 1'b1; rx_ready = 1'b0;
    clear_counts();
    cycles(3);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    cycles(4);

    // 1: single byte, consumer always ready
    clear_counts();
    rx_ready = 1'b1;
    send_byte(8'h03, 1'b1, 1'b0);
    cycles(2 * CPB);
    check("t1_valid_cycles", vcyc, 1);
    check("t1_data", {24'd0, acc_data}, 32'h03);
    check("t1_frame_err", ferr_cnt, 0);
    check("t1_overrun", ovr_cnt, 0);

    // 2: short low glitch on the idle line
    clear_counts();
    RX = 1'b0; cycles(5); RX = 1'b1;
    cycles(3 * CPB);
    check("t2_valid", vcyc, 0);
    check("t2_pulses", ferr_cnt + ovr_cnt, 0);
    check("t2_busy_le9", {31'd0, (busy_max <= 9)}, 32'd1);
    check("t2_busy_seen", {31'd0, (busy_max > 0)}, 32'd1);

    // 3: overrun while holding register is full
    clear_counts();
    rx_ready = 1'b0;
    send_byte(8'hA5, 1'b1, 1'b0);
    cycles(CPB);
    send_byte(8'h3C, 1'b1, 1'b0);
    cycles(2 * CPB);
    check("t3_valid_held", {31'd0, rx_valid}, 32'd1);
    check("t3_data_held", {24'd0, rx_data}, 32'hA5);
    check("t3_overrun_once", ovr_cnt, 1);
    rx_ready = 1'b1;
    cycles(1);
    check("t3_valid_cleared", {31'd0, rx_valid}, 32'd0);
    check("t3_accepted", {24'd0, acc_data}, 32'hA5);
    check("t3_accept_count", acc, 1);

    // 4: framing error followed by a held break
    clear_counts();
    send_byte(8'h55, 1'b0, 1'b0);
    RX = 1'b0; cycles(100); RX = 1'b1;
    cycles(2 * CPB);
    check("t4_frame_err_once", ferr_cnt, 1);
    check("t4_no_valid", vcyc, 0);
    check("t4_idle_after_break", {31'd0, busy}, 32'd0);
    clear_counts();
    send_byte(8'h01, 1'b1, 1'b0);
    cycles(2 * CPB);
    check("t4_next_count", acc, 1);
    check("t4_next_data", {24'd0, acc_data}, 32'h01);

    // 5: reset in the middle of data bit 4
    clear_counts();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cycles(CPB / 2);
    rst = 1'b1; cycles(2); rst = 1'b0;
    check("t5_busy_after_rst", {31'd0, busy}, 32'd0);
    cycles(12 * CPB);
    check("t5_no_output", vcyc + ferr_cnt + ovr_cnt, 0);
    send_byte(8'h02, 1'b1, 1'b0);
    cycles(2 * CPB);
    check("t5_count", acc, 1);
    check("t5_data", {24'd0, acc_data}, 32'h02);
    check("t5_pulses", ferr_cnt + ovr_cnt, 0);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then parity bad
    clear_counts();
    send_byte(8'h07, 1'b1, 1'b0);
    cycles(2 * CPB);
    check("t6_good_data", {24'd0, acc_data}, 32'h07);
    check("t6_good_perr", perr_cnt, 0);
    clear_counts();
    send_byte(8'h07, 1'b1, 1'b1);
    cycles(2 * CPB);
    check("t6_bad_perr", perr_cnt, 1);
    check("t6_bad_delivered", acc, 1);
    check("t6_bad_data", {24'd0, acc_data}, 32'h07);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
